// File: rtl/iterative_divider.sv
// Purpose: RV32M DIV/DIVU/REM/REMU unit using restoring division, one quotient bit per cycle.
// Latency: WIDTH+2 cycles from the accepting edge to done (1 cycle for divide-by-zero / signed overflow).
// Backpressure: o_busy holds the pipeline; i_start is ignored while busy and accepted in IDLE or DONE.
//
// Ports:
//   i_clk, i_reset        clock and synchronous active-high reset
//   i_start               request a division (sampled only in IDLE or DONE)
//   i_op                  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   i_dividend, i_divisor rs1 / rs2, latched with i_start
//   o_busy                high during CALC and ADJUST of a normal operation
//   o_done                one-cycle pulse, o_result valid in that cycle
//   o_result              quotient or remainder, held until the next accepted start

// (W+1)-bit style adder used for the trial subtraction: result = a + b + cin.
module fullAdder #(
   parameter int WIDTH = 33
) (
   input  logic [WIDTH-1:0] i_operand1,
   input  logic [WIDTH-1:0] i_operand2,
   input  logic             i_cin,
   output logic [WIDTH-1:0] o_result,
   output logic             o_cout
);
   assign {o_cout, o_result} = {1'b0, i_operand1} + {1'b0, i_operand2} + (WIDTH+1)'(i_cin);
endmodule

module iterative_divider #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic [1:0]       i_op,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_result
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CALC   = 2'd1,
      S_ADJUST = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_next;

   // Latched operation context
   logic             r_op_rem;      // 1: return remainder, 0: return quotient
   logic             r_neg_q;
   logic             r_neg_r;
   logic             r_special;     // operand pair bypasses CALC
   logic [WIDTH-1:0] r_spec_res;
   logic [WIDTH-1:0] r_dvd_mag;
   logic [WIDTH-1:0] r_dvs_mag;

   // Iteration state
   logic [WIDTH:0]   r_rem;         // partial remainder, WIDTH+1 bits
   logic [WIDTH-1:0] r_quo;         // dividend shifts out, quotient shifts in
   logic [CW-1:0]    r_cnt;
   logic             r_seeded;      // first CALC cycle loads rem/quo, iterations follow
   logic [WIDTH-1:0] r_result;

   // Accept-side decode
   logic             w_accept;
   logic             w_signed;
   logic             w_dvd_neg;
   logic             w_dvs_neg;
   logic [WIDTH-1:0] w_dvd_mag;
   logic [WIDTH-1:0] w_dvs_mag;
   logic             w_div_zero;
   logic             w_overflow;
   logic             w_special;
   logic [WIDTH-1:0] w_spec_res;

   // Iteration datapath
   logic [WIDTH:0]   w_rem_sh;
   logic [WIDTH:0]   w_sub;
   logic             w_cout;
   logic [WIDTH-1:0] w_quo_adj;
   logic [WIDTH-1:0] w_rem_lo;
   logic [WIDTH-1:0] w_rem_adj;
   logic             w_unused;

   assign w_accept   = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_signed   = ~i_op[0];
   assign w_dvd_neg  = w_signed & i_dividend[WIDTH-1];
   assign w_dvs_neg  = w_signed & i_divisor[WIDTH-1];
   // Unsigned negation keeps the most negative value exact as 2^(WIDTH-1).
   assign w_dvd_mag  = w_dvd_neg ? (~i_dividend + 1'b1) : i_dividend;
   assign w_dvs_mag  = w_dvs_neg ? (~i_divisor + 1'b1) : i_divisor;

   assign w_div_zero = (i_divisor == '0);
   assign w_overflow = w_signed && (i_dividend == MOST_NEG) && (i_divisor == '1);
   assign w_special  = w_div_zero | w_overflow;

   always_comb begin
      w_spec_res = '0;
      if (w_div_zero) begin
         w_spec_res = i_op[1] ? i_dividend : '1;
      end else if (w_overflow) begin
         w_spec_res = i_op[1] ? '0 : i_dividend;
      end
   end

   // Shift the next dividend bit into the partial remainder, then trial-subtract.
   assign w_rem_sh = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};

   fullAdder #(.WIDTH(WIDTH+1)) u_sub (
      .i_operand1 (w_rem_sh),
      .i_operand2 (~{1'b0, r_dvs_mag}),
      .i_cin      (1'b1),
      .o_result   (w_sub),
      .o_cout     (w_cout)
   );

   // Top remainder bit is always 0 once restored (rem < divisor), so only the low bits feed back.
   assign w_unused  = r_rem[WIDTH];

   assign w_rem_lo  = r_rem[WIDTH-1:0];
   assign w_quo_adj = r_neg_q ? (~r_quo + 1'b1) : r_quo;
   assign w_rem_adj = (r_neg_r && (w_rem_lo != '0)) ? (~w_rem_lo + 1'b1) : w_rem_lo;

   // Next-state and status outputs
   always_comb begin
      w_next = r_state;
      o_busy = 1'b0;
      o_done = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_next = w_special ? S_ADJUST : S_CALC;
            end
         end
         S_CALC: begin
            o_busy = 1'b1;
            if (r_seeded && (r_cnt == CW'(WIDTH-1))) begin
               w_next = S_ADJUST;
            end
         end
         S_ADJUST: begin
            // Special cases pass through ADJUST only to register the result.
            o_busy = ~r_special;
            w_next = S_DONE;
         end
         S_DONE: begin
            o_done = 1'b1;
            if (i_start) begin
               w_next = w_special ? S_ADJUST : S_CALC;
            end else begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= S_IDLE;
         r_op_rem   <= 1'b0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_special  <= 1'b0;
         r_spec_res <= '0;
         r_dvd_mag  <= '0;
         r_dvs_mag  <= '0;
         r_rem      <= '0;
         r_quo      <= '0;
         r_cnt      <= '0;
         r_seeded   <= 1'b0;
         r_result   <= '0;
      end else begin
         r_state <= w_next;

         if (w_accept) begin
            r_op_rem   <= i_op[1];
            r_neg_q    <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r    <= w_dvd_neg;
            r_special  <= w_special;
            r_spec_res <= w_spec_res;
            r_dvd_mag  <= w_dvd_mag;
            r_dvs_mag  <= w_dvs_mag;
            r_cnt      <= '0;
            r_seeded   <= 1'b0;
         end

         case (r_state)
            S_CALC: begin
               if (!r_seeded) begin
                  r_rem    <= '0;
                  r_quo    <= r_dvd_mag;
                  r_seeded <= 1'b1;
               end else begin
                  // cout = 1 means no borrow: the divisor fits, keep the difference.
                  r_rem <= w_cout ? w_sub : w_rem_sh;
                  r_quo <= {r_quo[WIDTH-2:0], w_cout};
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_ADJUST: begin
               if (r_special) begin
                  r_result <= r_spec_res;
               end else begin
                  r_result <= r_op_rem ? w_rem_adj : w_quo_adj;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_result = r_result;

endmodule

// File: tb/tb_iterative_divider.sv
module tb_iterative_divider;

   localparam int W = 32;
   localparam int NORMAL_LAT = W + 2;

   logic          i_clk = 1'b0;
   logic          i_reset;
   logic          i_start;
   logic [1:0]    i_op;
   logic [W-1:0]  i_dividend;
   logic [W-1:0]  i_divisor;
   logic          o_busy;
   logic          o_done;
   logic [W-1:0]  o_result;

   int total = 0;
   int bad   = 0;

   iterative_divider #(.WIDTH(W)) dut (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_start    (i_start),
      .i_op       (i_op),
      .i_dividend (i_dividend),
      .i_divisor  (i_divisor),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_result   (o_result)
   );

   always #5 i_clk = ~i_clk;

   // Reference: RISC-V M-extension semantics in plain arithmetic.
   function automatic logic [W-1:0] ref_result(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic signed [W-1:0] sa;
      logic signed [W-1:0] sb;
      sa = a;
      sb = b;
      if (b == 0) return op[1] ? a : {W{1'b1}};
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? '0 : a;
      case (op)
         2'b00:   return sa / sb;
         2'b01:   return a / b;
         2'b10:   return sa % sb;
         default: return a % b;
      endcase
   endfunction

   function automatic int ref_latency(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      if (b == 0) return 1;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return NORMAL_LAT;
   endfunction

   // Drives one start from the current (between-edges) time and waits for done.
   // Leaves the caller #1 after the edge that raised done, i.e. inside the done cycle.
   task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int busy_cnt, output int anomalies, output logic [W-1:0] res);
      i_op       = op;
      i_dividend = a;
      i_divisor  = b;
      i_start    = 1'b1;
      @(posedge i_clk);
      #1;
      i_start   = 1'b0;
      lat       = -1;
      busy_cnt  = 0;
      anomalies = 0;
      if (o_busy) busy_cnt++;
      if (o_done) anomalies++;
      for (int k = 1; k <= 100 && lat < 0; k++) begin
         @(posedge i_clk);
         #1;
         if (o_busy && o_done) anomalies++;
         if (o_busy) busy_cnt++;
         if (o_done) lat = k;
      end
      res = o_result;
   endtask

   task automatic test_reset();
      i_reset = 1'b1; i_start = 1'b0; i_op = '0; i_dividend = '0; i_divisor = '0;
      repeat (3) @(posedge i_clk);
      #1;
      total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", o_busy); end
      total++; if (o_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", o_done); end
      total++; if (o_result !== '0) begin bad++; $display("FAIL reset_result got=%h want=0", o_result); end
      i_reset = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;
   endtask

   task automatic test_directed();
      logic [1:0]   t_op  [12];
      logic [W-1:0] t_a   [12];
      logic [W-1:0] t_b   [12];
      logic [W-1:0] t_exp [12];
      int           t_lat [12];
      int lat, bc, an;
      logic [W-1:0] res;
      t_op[0]  = 2'b01; t_a[0]  = 100;           t_b[0]  = 7;             t_exp[0]  = 14;            t_lat[0]  = 34;
      t_op[1]  = 2'b11; t_a[1]  = 100;           t_b[1]  = 7;             t_exp[1]  = 2;             t_lat[1]  = 34;
      t_op[2]  = 2'b00; t_a[2]  = 32'hFFFFFFF9;  t_b[2]  = 2;             t_exp[2]  = 32'hFFFFFFFD;  t_lat[2]  = 34;
      t_op[3]  = 2'b10; t_a[3]  = 32'hFFFFFFF9;  t_b[3]  = 2;             t_exp[3]  = 32'hFFFFFFFF;  t_lat[3]  = 34;
      t_op[4]  = 2'b10; t_a[4]  = 7;             t_b[4]  = 32'hFFFFFFFE;  t_exp[4]  = 1;             t_lat[4]  = 34;
      t_op[5]  = 2'b01; t_a[5]  = 32'h1234;      t_b[5]  = 0;             t_exp[5]  = 32'hFFFFFFFF;  t_lat[5]  = 1;
      t_op[6]  = 2'b10; t_a[6]  = 32'h1234;      t_b[6]  = 0;             t_exp[6]  = 32'h1234;      t_lat[6]  = 1;
      t_op[7]  = 2'b00; t_a[7]  = 32'h80000000;  t_b[7]  = 32'hFFFFFFFF;  t_exp[7]  = 32'h80000000;  t_lat[7]  = 1;
      t_op[8]  = 2'b10; t_a[8]  = 32'h80000000;  t_b[8]  = 32'hFFFFFFFF;  t_exp[8]  = 0;             t_lat[8]  = 1;
      t_op[9]  = 2'b01; t_a[9]  = 32'h80000000;  t_b[9]  = 32'hFFFFFFFF;  t_exp[9]  = 0;             t_lat[9]  = 34;
      t_op[10] = 2'b00; t_a[10] = 32'h80000000;  t_b[10] = 2;             t_exp[10] = 32'hC0000000;  t_lat[10] = 34;
      t_op[11] = 2'b00; t_a[11] = 5;             t_b[11] = 0;             t_exp[11] = 32'hFFFFFFFF;  t_lat[11] = 1;
      for (int i = 0; i < 12; i++) begin
         run_op(t_op[i], t_a[i], t_b[i], lat, bc, an, res);
         total++; if (res !== t_exp[i]) begin bad++; $display("FAIL directed_result[%0d] got=%h want=%h", i, res, t_exp[i]); end
         total++; if (lat !== t_lat[i]) begin bad++; $display("FAIL directed_latency[%0d] got=%0d want=%0d", i, lat, t_lat[i]); end
         total++; if (bc !== ((t_lat[i] == 1) ? 0 : t_lat[i])) begin bad++; $display("FAIL directed_busy_cycles[%0d] got=%0d want=%0d", i, bc, (t_lat[i] == 1) ? 0 : t_lat[i]); end
         total++; if (an !== 0) begin bad++; $display("FAIL directed_busy_done_overlap[%0d] got=%0d want=0", i, an); end
         // Idle a few cycles: done must drop and the result must stay put.
         repeat (3) @(posedge i_clk);
         #1;
         total++; if (o_done !== 1'b0 || o_result !== t_exp[i]) begin bad++; $display("FAIL directed_hold[%0d] done=%b result=%h want done=0 result=%h", i, o_done, o_result, t_exp[i]); end
      end
   endtask

   task automatic test_random();
      int lat, bc, an;
      logic [W-1:0] res, a, b, exp_r;
      logic [1:0] op;
      int exp_lat;
      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         case ($urandom_range(0, 7))
            0:       b = '0;
            1:       begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            2:       b = $urandom_range(1, 15);
            3:       b = -($urandom_range(1, 15));
            4:       begin a = $urandom_range(0, 1000); b = $urandom; end
            default: b = $urandom;
         endcase
         exp_r   = ref_result(op, a, b);
         exp_lat = ref_latency(op, a, b);
         run_op(op, a, b, lat, bc, an, res);
         total++; if (res !== exp_r) begin bad++; $display("FAIL random_result op=%0d a=%h b=%h got=%h want=%h", op, a, b, res, exp_r); end
         total++; if (lat !== exp_lat) begin bad++; $display("FAIL random_latency op=%0d a=%h b=%h got=%0d want=%0d", op, a, b, lat, exp_lat); end
         total++; if (bc !== ((exp_lat == 1) ? 0 : exp_lat) || an !== 0) begin bad++; $display("FAIL random_busy op=%0d busy_cycles=%0d overlap=%0d want busy_cycles=%0d overlap=0", op, bc, an, (exp_lat == 1) ? 0 : exp_lat); end
         // Every other op runs back-to-back (start asserted during the done cycle).
         if (i % 2 == 1) begin
            repeat ($urandom_range(1, 3)) @(posedge i_clk);
            #1;
         end
      end
   endtask

   task automatic test_back_to_back();
      int lat, bc, an;
      logic [W-1:0] res;
      logic [W-1:0] a2, b2;
      a2 = $urandom;
      b2 = $urandom_range(1, 50000);
      // DIVU 1000/10 with a stray start pulse at cycle 10.
      i_op = 2'b01; i_dividend = 1000; i_divisor = 10; i_start = 1'b1;
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      repeat (9) @(posedge i_clk);
      #1;
      i_op = 2'b10; i_dividend = 32'hDEADBEEF; i_divisor = 3; i_start = 1'b1;
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      lat = -1;
      for (int k = 11; k <= 100 && lat < 0; k++) begin
         @(posedge i_clk);
         #1;
         if (o_done) lat = k;
      end
      total++; if (o_result !== 32'd100) begin bad++; $display("FAIL ignored_start_result got=%h want=%h", o_result, 32'd100); end
      total++; if (lat !== NORMAL_LAT) begin bad++; $display("FAIL ignored_start_latency got=%0d want=%0d", lat, NORMAL_LAT); end
      // Still inside the done cycle: the next start is accepted immediately.
      run_op(2'b01, a2, b2, lat, bc, an, res);
      total++; if (res !== a2 / b2) begin bad++; $display("FAIL b2b_result got=%h want=%h", res, a2 / b2); end
      total++; if (lat !== NORMAL_LAT || an !== 0) begin bad++; $display("FAIL b2b_latency got=%0d overlap=%0d want=%0d overlap=0", lat, an, NORMAL_LAT); end
   endtask

   task automatic test_reset_mid_calc();
      int seen;
      int lat, bc, an;
      logic [W-1:0] res;
      i_op = 2'b00; i_dividend = 32'hFFFF0000; i_divisor = 77; i_start = 1'b1;
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      repeat (14) @(posedge i_clk);
      #1;
      i_reset = 1'b1;
      @(posedge i_clk);
      #1;
      i_reset = 1'b0;
      total++; if (o_busy !== 1'b0 || o_done !== 1'b0 || o_result !== '0) begin bad++; $display("FAIL reset_mid_calc busy=%b done=%b result=%h want 0 0 0", o_busy, o_done, o_result); end
      seen = 0;
      repeat (60) begin
         @(posedge i_clk);
         #1;
         if (o_done || o_busy) seen++;
      end
      total++; if (seen !== 0) begin bad++; $display("FAIL reset_no_done got=%0d active cycles want=0", seen); end
      run_op(2'b11, 32'd1000, 32'd7, lat, bc, an, res);
      total++; if (res !== 32'd6 || lat !== NORMAL_LAT) begin bad++; $display("FAIL after_reset_op got=%h lat=%0d want=%h lat=%0d", res, lat, 32'd6, NORMAL_LAT); end
   endtask

   initial begin
      i_reset = 1'b1; i_start = 1'b0; i_op = '0; i_dividend = '0; i_divisor = '0;
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_mid_calc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
